// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and default sizes for the FIFO stream reader:
//                output-buffer occupancy encoding and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int unsigned c_DWIDTH_DEFAULT = 32;
    localparam int unsigned c_AWIDTH_DEFAULT = 4;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    // Number of words held for a given occupancy state
    function automatic logic [1:0] occ_count(input occ_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_buf
//  Description : 2-entry in-order output buffer. Words are pushed in and
//                presented on a valid/ready stream; data_o is always the
//                oldest word, valid_o is a register.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = c_DWIDTH_DEFAULT
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWIDTH-1:0] data_o,
    output occ_e              occ_o
);

    occ_e              occ_q, occ_d;
    logic [DWIDTH-1:0] head_q, head_d;   // oldest word, drives data_o
    logic [DWIDTH-1:0] tail_q, tail_d;   // second word when occupancy is TWO
    logic              valid_q;
    logic              pop;

    assign pop     = valid_q && ready_i;
    assign valid_o = valid_q;
    assign data_o  = head_q;
    assign occ_o   = occ_q;

    // Next occupancy and entry contents from push/pop; order is head then tail
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            EMPTY: begin
                if (push_i) begin
                    head_d = data_i;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                case ({push_i, pop})
                    2'b11: head_d = data_i;
                    2'b10: begin
                        tail_d = data_i;
                        occ_d  = TWO;
                    end
                    2'b01: occ_d = EMPTY;
                    default: occ_d = ONE;
                endcase
            end
            TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = data_i;
                    end else begin
                        occ_d = ONE;
                    end
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    // Occupancy state machine with registered valid output
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            occ_q   <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= (occ_d != EMPTY);
        end
    end

    // A full buffer may only accept a word when the head leaves on the same edge
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        !((occ_q == TWO) && push_i && !pop));

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Drains a FIFO (show-ahead or normal read mode) into a
//                valid/ready stream through a 2-entry buffer, sustaining one
//                word per cycle. Read requests are issued only when buffer
//                space (counting an in-flight read) is guaranteed.
//                Optional feature macro FIFO_STREAM_READER_STATS_EN adds a
//                32-bit wrapping handshake counter on words_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH    = c_DWIDTH_DEFAULT,
    parameter int unsigned AWIDTH    = c_AWIDTH_DEFAULT,
    parameter bit          SHOWAHEAD = 1'b1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [31:0]       words_cnt_o
`endif
);

    occ_e       occ;
    logic       inflight;
    logic       push;
    logic       handshake;
    logic [1:0] committed;
    logic       credit;

    // The FIFO address width only sizes the external usedw bus; reject nonsense
    if (AWIDTH < 1) begin : g_awidth_check
        $error("fifo_stream_reader: AWIDTH must be at least 1");
    end

    assign handshake = valid_o && ready_i;

    // Words already owned by this block: buffered plus the one in flight
    assign committed = occ_count(occ) + {1'b0, inflight};
    assign credit    = (committed < 2'd2) || ((committed == 2'd2) && handshake);

    assign fifo_rdreq_o = arst_n_i && !fifo_empty_i && credit;

    if (SHOWAHEAD) begin : g_showahead
        // FIFO q already shows the head word; capture on the request edge
        assign inflight = 1'b0;
        assign push     = fifo_rdreq_o;
    end else begin : g_normal_read
        logic inflight_q;

        // Remember a request so its data is captured one cycle later
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= fifo_rdreq_o;
            end
        end

        assign inflight = inflight_q;
        assign push     = inflight_q;
    end

    stream_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .push_i   (push),
        .data_i   (fifo_q_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .occ_o    (occ)
    );

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [31:0] words_cnt_q;

    // Count delivered words; wraps naturally at 32 bits
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            words_cnt_q <= '0;
        end else if (handshake) begin
            words_cnt_q <= words_cnt_q + 32'd1;
        end
    end

    assign words_cnt_o = words_cnt_q;
`endif

endmodule
`default_nettype wire
